// File: rtl/axi_read_arbiter_if.sv
// AXI4 read channel bundle (AR + R) shared by the requester ports and the bus port.
// master drives AR and rready; slave drives arready and the R payload.
interface axi_read_arbiter_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin AR grant held until the final R beat,
// with a beat-count check of the returned burst against the granted arlen.
module axi_read_arbiter #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s,
  output logic               o_grant,
  output logic               o_busy,
  output logic               o_len_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic RST_OWNER = 1'(RESET_PRIO);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic                  last_owner;
  logic                  pick;
  logic [7:0]            len_q;
  logic [8:0]            beat_cnt;
  logic                  len_err_d;

  logic                  sel_arvalid;
  logic                  sel_rready;
  logic [7:0]            sel_arlen;
  logic [ID_WIDTH-1:0]   sel_arid;
  logic [DATA_WIDTH-1:0] rdata_bcast;
  logic                  ar_hs;
  logic                  r_hs;

  // Owner-selected request side; only observed by the bus while in ADDR/DATA.
  assign sel_arvalid = o_grant ? m1.arvalid : m0.arvalid;
  assign sel_rready  = o_grant ? m1.rready  : m0.rready;
  assign sel_arlen   = o_grant ? m1.arlen   : m0.arlen;
  assign sel_arid    = o_grant ? m1.arid    : m0.arid;

  assign s.araddr  = o_grant ? m1.araddr  : m0.araddr;
  assign s.arid    = sel_arid;
  assign s.arlen   = sel_arlen;
  assign s.arsize  = o_grant ? m1.arsize  : m0.arsize;
  assign s.arburst = o_grant ? m1.arburst : m0.arburst;

  // R payload is broadcast; only rvalid is steered to the owner.
  assign rdata_bcast = s.rdata;
  assign m0.rdata    = rdata_bcast;
  assign m1.rdata    = rdata_bcast;
  assign m0.rresp    = s.rresp;
  assign m1.rresp    = s.rresp;
  assign m0.rlast    = s.rlast;
  assign m1.rlast    = s.rlast;
  assign m0.rid      = s.rid;
  assign m1.rid      = s.rid;

  assign ar_hs  = (state == ADDR) && sel_arvalid && s.arready;
  assign r_hs   = (state == DATA) && s.rvalid && sel_rready;
  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pick       = o_grant;
    len_err_d  = 1'b0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (m0.arvalid && m1.arvalid) begin
          pick = ~last_owner;
        end else begin
          pick = m1.arvalid;
        end
        if (m0.arvalid || m1.arvalid) begin
          next_state = ADDR;
        end
      end
      ADDR: begin
        s.arvalid  = sel_arvalid;
        m0.arready = ~o_grant & s.arready;
        m1.arready =  o_grant & s.arready;
        if (ar_hs) begin
          next_state = DATA;
        end
      end
      DATA: begin
        s.rready  = sel_rready;
        m0.rvalid = ~o_grant & s.rvalid;
        m1.rvalid =  o_grant & s.rvalid;
        // beat_cnt is the index of the current beat; the last one must be index len_q.
        if (r_hs) begin
          if (s.rlast) begin
            next_state = IDLE;
            len_err_d  = (beat_cnt != {1'b0, len_q});
          end else begin
            len_err_d  = (beat_cnt == {1'b0, len_q});
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_grant    <= RST_OWNER;
      last_owner <= ~RST_OWNER;
      len_q      <= 8'd0;
      beat_cnt   <= 9'd0;
      o_len_err  <= 1'b0;
    end else begin
      o_len_err <= len_err_d;
      if ((state == IDLE) && (next_state == ADDR)) begin
        o_grant <= pick;
      end
      if (ar_hs) begin
        len_q    <= sel_arlen;
        beat_cnt <= 9'd0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (s.rlast) begin
          last_owner <= o_grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: scoreboard queues for AR and R traffic
// plus per-scenario inline checks.
module tb_axi_read_arbiter;

  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } ar_exp_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rd_exp_t;

  logic clk;
  logic rst;
  logic grant;
  logic busy;
  logic len_err;

  int checks;
  int failures;

  ar_exp_t ar_q[$];
  rd_exp_t rd_q[$];
  ar_exp_t ea;
  rd_exp_t er;
  logic [1:0] rv;
  logic [1:0] rr;
  logic [1:0] ar_rdy;

  axi_read_arbiter_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) m0_if ();
  axi_read_arbiter_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) m1_if ();
  axi_read_arbiter_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) s_if ();

  axi_read_arbiter #(.ID_WIDTH(4), .DATA_WIDTH(32), .RESET_PRIO(0)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_len_err (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard monitor: pops expected AR/R items when the DUT completes a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      ar_rdy = {m1_if.arready, m0_if.arready};
      rv     = {m1_if.rvalid, m0_if.rvalid};
      rr     = {m1_if.rready, m0_if.rready};
      checks++;
      if (s_if.arvalid && s_if.arready) begin
        if (ar_q.size() == 0) begin
          failures++;
          $display("FAIL ar_unexpected: got addr=%h with nothing expected", s_if.araddr);
        end else begin
          ea = ar_q.pop_front();
          if (s_if.araddr !== ea.addr || s_if.arid !== ea.id || s_if.arlen !== ea.len ||
              s_if.arsize !== 3'd2 || s_if.arburst !== 2'b01 || grant !== 1'(ea.who) ||
              ar_rdy !== 2'(32'd1 << ea.who)) begin
            failures++;
            $display("FAIL ar_handshake: got addr=%h id=%h len=%0d grant=%0d arready=%b, want addr=%h id=%h len=%0d owner=%0d",
                     s_if.araddr, s_if.arid, s_if.arlen, grant, ar_rdy, ea.addr, ea.id, ea.len, ea.who);
          end
        end
      end else if (ar_rdy !== 2'b00) begin
        failures++;
        $display("FAIL arready_idle: got arready=%b with no bus handshake, want 00", ar_rdy);
      end
      if (rv == 2'b11) begin
        failures++;
        $display("FAIL rvalid_both: got rvalid=%b, want at most one", rv);
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[n] && (rd_q.size() == 0 || rd_q[0].who != n)) begin
          failures++;
          $display("FAIL r_route: requester %0d got rvalid, want no beat routed to it", n);
        end else if (rv[n] && rr[n]) begin
          checks++;
          er = rd_q.pop_front();
          if (m0_if.rdata !== er.data || m1_if.rdata !== er.data || m0_if.rresp !== er.resp ||
              m0_if.rlast !== er.last || m1_if.rid !== er.id || s_if.rready !== 1'b1) begin
            failures++;
            $display("FAIL r_beat: m%0d got data=%h resp=%0d last=%b id=%h rready=%b, want data=%h resp=%0d last=%b id=%h",
                     n, m0_if.rdata, m0_if.rresp, m0_if.rlast, m1_if.rid, s_if.rready,
                     er.data, er.resp, er.last, er.id);
          end
        end
      end
    end
  end

  task automatic req(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    if (m == 0) begin
      m0_if.araddr = addr; m0_if.arid = id; m0_if.arlen = len; m0_if.arvalid = 1'b1;
    end else begin
      m1_if.araddr = addr; m1_if.arid = id; m1_if.arlen = len; m1_if.arvalid = 1'b1;
    end
    ar_q.push_back('{who: m, addr: addr, id: id, len: len});
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) m0_if.rready = v;
    else        m1_if.rready = v;
  endtask

  // Waits for the bus AR, holds arready low for 'delay' cycles, then accepts it.
  task automatic ar_accept(input int m, input int delay, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (s_if.arvalid !== 1'b1) begin
      if (n >= 16) begin
        failures++;
        $display("FAIL ar_timeout: s_arvalid never rose for m%0d", m);
        return;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != exp_lat || grant !== 1'(m) || busy !== 1'b1) begin
      failures++;
      $display("FAIL ar_grant: got latency=%0d grant=%0d busy=%b, want latency=%0d grant=%0d busy=1",
               n, grant, busy, exp_lat, m);
    end
    for (int i = 1; i < delay; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_if.arready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_if.arready = 1'b0;
    if (m == 0) m0_if.arvalid = 1'b0;
    else        m1_if.arvalid = 1'b0;
  endtask

  // Drives R beats; bit b of err_mask expects o_len_err after beat b, skip_mask suppresses the check.
  task automatic do_r(input int m, input int nbeats, input int rlast_at, input int stall,
                      input int err_mask, input int skip_mask);
    logic [31:0] d;
    for (int b = 1; b <= nbeats; b++) begin
      d = $urandom;
      s_if.rvalid = 1'b1;
      s_if.rdata  = d;
      s_if.rresp  = 2'(b);
      s_if.rlast  = (b == rlast_at);
      s_if.rid    = 4'(b + 5);
      rd_q.push_back('{who: m, data: d, resp: 2'(b), last: (b == rlast_at), id: 4'(b + 5)});
      set_rready(m, (b > 1) || (stall == 0));
      if (b == 1) begin
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          checks++;
          if (s_if.rready !== 1'b0 || (m == 0 ? m0_if.rvalid : m1_if.rvalid) !== 1'b1) begin
            failures++;
            $display("FAIL r_stall: cycle %0d got s_rready=%b, want 0 with rvalid held", i, s_if.rready);
          end
          @(posedge clk); #1;
        end
        set_rready(m, 1'b1);
      end
      @(negedge clk);
      @(posedge clk); #1;
      s_if.rvalid = 1'b0;
      s_if.rlast  = 1'b0;
      @(negedge clk);
      if (((skip_mask >> b) & 1) == 0) begin
        checks++;
        if (len_err !== 1'((err_mask >> b) & 1)) begin
          failures++;
          $display("FAIL len_err: beat %0d got %b, want %0d", b, len_err, (err_mask >> b) & 1);
        end
      end
      if (b == rlast_at) begin
        checks++;
        if (busy !== 1'b0 || s_if.rready !== 1'b0) begin
          failures++;
          $display("FAIL end_of_burst: got busy=%b s_rready=%b, want 0 0", busy, s_if.rready);
        end
      end
      @(posedge clk); #1;
    end
    set_rready(m, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 1'b0 || len_err !== 1'b0 || s_if.arvalid !== 1'b0 ||
        s_if.rready !== 1'b0 || m0_if.arready !== 1'b0 || m1_if.arready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b grant=%b len_err=%b s_arvalid=%b s_rready=%b, want all 0",
               busy, grant, len_err, s_if.arvalid, s_if.rready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    req(0, 32'h8000_0000, 4'h3, 8'd3);
    ar_accept(0, 2, 1);
    do_r(0, 4, 4, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    req(0, 32'h1000_0000, 4'h1, 8'd0);
    req(1, 32'h2000_0000, 4'h2, 8'd0);
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      ar_accept(w, 1, (k == 0) ? 1 : 0);
      if (k < 2) req(w, 32'h1000_0000 + 32'(k + 1) * 32'h100 + 32'(w) * 32'h1000_0000, 4'(k + 8), 8'(k % 2));
      do_r(w, (k < 2) ? 1 : (k % 2) + 1, (k < 2) ? 1 : (k % 2) + 1, 0, 0, 0);
    end
  endtask

  task automatic test_lock();
    req(0, 32'h3000_0040, 4'h4, 8'd2);
    ar_accept(0, 1, 1);
    req(1, 32'h4000_0080, 4'h5, 8'd1);
    @(negedge clk);
    checks++;
    if (s_if.arvalid !== 1'b0 || grant !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lock: got s_arvalid=%b grant=%b busy=%b during m0 data, want 0 0 1",
               s_if.arvalid, grant, busy);
    end
    @(posedge clk); #1;
    do_r(0, 3, 3, 0, 0, 0);
    ar_accept(1, 1, 0);
    do_r(1, 2, 2, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    req(1, 32'h0f00_0000, 4'h6, 8'd0);
    ar_accept(1, 1, 1);
    do_r(1, 1, 1, 3, 0, 0);
  endtask

  task automatic test_len_err();
    req(0, 32'h5000_0000, 4'h7, 8'd3);
    ar_accept(0, 1, 1);
    do_r(0, 2, 2, 0, 32'd1 << 2, 0);
    req(0, 32'h5000_1000, 4'h8, 8'd3);
    ar_accept(0, 1, 1);
    do_r(0, 5, 5, 0, 32'd1 << 4, 32'd1 << 5);
  endtask

  task automatic test_reset_mid_burst();
    req(1, 32'h6000_0000, 4'h9, 8'd3);
    ar_accept(1, 1, 1);
    do_r(1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_if.rvalid = 1'b1;
    s_if.rlast  = 1'b0;
    m1_if.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_if.rready !== 1'b0 || grant !== 1'b0 || m1_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b s_rready=%b grant=%b m1_rvalid=%b, want 0 0 0 0",
               busy, s_if.rready, grant, m1_if.rvalid);
    end
    @(posedge clk); #1;
    s_if.rvalid  = 1'b0;
    m1_if.rready = 1'b0;
    req(1, 32'h6000_2000, 4'ha, 8'd1);
    ar_accept(1, 1, 1);
    do_r(1, 2, 2, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
    m0_if.arsize = 3'd2; m0_if.arburst = 2'b01; m0_if.rready = 1'b0;
    m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
    m1_if.arsize = 3'd2; m1_if.arburst = 2'b01; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
    s_if.rresp = '0; s_if.rlast = 1'b0; s_if.rid = '0;

    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_len_err();
    test_reset_mid_burst();

    repeat (3) @(posedge clk);
    checks++;
    if (ar_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d AR and %0d R items outstanding, want 0 0", ar_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI4 read master port between two requesters:
  - m0: instruction cache refill and uncached fetch.
  - m1: LSU data reads.
- Sits between the fetch/LSU stages and the system bus.
- Grants the AR channel round-robin and locks the grant until the final R beat (rlast) of the granted burst.
- Checks the returned beat count against the granted arlen and flags mismatches.

Parameters:
- ID_WIDTH, 4, width of arid/rid.
- DATA_WIDTH, 32, R data width.
- RESET_PRIO, 0, requester index favoured on the first arbitration after reset.

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  synchronous active-high reset.
- mN_arvalid (N=0,1)  input  1  requester address valid.
- mN_araddr/mN_arid/mN_arlen/mN_arsize/mN_arburst  input  32/ID_WIDTH/8/3/2  requester AR payload.
- mN_arready  output  1  AR accepted.
- mN_rvalid  output  1  R beat valid for this requester.
- mN_rdata/mN_rresp/mN_rlast/mN_rid  output  DATA_WIDTH/2/1/ID_WIDTH  R payload (broadcast from the slave).
- mN_rready  input  1  requester ready.
- s_arvalid  output  1  to bus.
- s_araddr/s_arid/s_arlen/s_arsize/s_arburst  output  32/ID_WIDTH/8/3/2  to bus.
- s_arready  input  1  from bus.
- s_rvalid/s_rdata/s_rresp/s_rlast/s_rid  input  1/DATA_WIDTH/2/1/ID_WIDTH  from bus.
- s_rready  output  1  to bus.
- o_grant  output  1  index of the current owner (valid when o_busy).
- o_busy  output  1  a transaction is in ADDR or DATA.
- o_len_err  output  1  single-cycle pulse on a beat-count mismatch.

Behaviour:
- States:
  - IDLE: no grant.
  - ADDR: AR channel muxed to the owner.
  - DATA: R channel routed to the owner.
- IDLE:
  - Exactly one mN_arvalid: grant N and go to ADDR next cycle.
  - Both valid: grant the index != last_owner.
  - No request: stay in IDLE.
  - No AR handshake happens in IDLE, so arbitration latency is 1 cycle.
- ADDR:
  - s_ar* = owner's ar* (combinational mux).
  - Owner's arready = s_arready; the other requester's arready = 0.
  - On s_arvalid & s_arready: latch arlen into len_q, clear beat_cnt, go to DATA.
  - Requesters must hold arvalid and payload stable until arready (AXI rule). Dropping arvalid while in ADDR is illegal and is not checked.
- DATA:
  - s_rready = owner's rready.
  - Owner's rvalid = s_rvalid; the other requester's rvalid = 0.
  - rdata/rresp/rlast/rid are broadcast to both requesters.
  - Each handshake increments beat_cnt (9-bit, cannot wrap since arlen ≤ 255).
  - On a handshake with s_rlast:
    - Go to IDLE.
    - Set last_owner = owner.
    - o_len_err pulses if beat_cnt != len_q at that beat (rlast early or late).
  - Handshake without rlast when beat_cnt == len_q: pulse o_len_err and remain in DATA until rlast.
- Outside ADDR: s_arvalid = 0 and all mN_arready = 0.
- Outside DATA: s_rready = 0 and all mN_rvalid = 0.
- rresp is passed through unchanged; errors do not alter sequencing.
- A requester may assert arvalid for its next request during DATA. It is ignored until IDLE, so there are no back-to-back overlapped transactions.
- Reset:
  - Values after reset: state = IDLE, o_busy = 0, o_grant = RESET_PRIO, o_len_err = 0.
  - last_owner = 1 - RESET_PRIO.
  - Reset asserted mid-burst abandons the burst immediately. The bus is reset concurrently, so remaining beats are not drained.
- Outputs:
  - o_busy = (state != IDLE).
  - o_grant is a register, updated only on the IDLE→ADDR transition.

Test Plan:
- Single request: m0 requests araddr=0x80000000, arlen=3, with s_arready delayed 2 cycles → s_arvalid high one cycle after m0_arvalid. m0_arready pulses exactly at the bus handshake. 4 beats reach m0, m1_rvalid stays 0, o_busy drops the cycle after rlast.
- Simultaneous requests after reset (RESET_PRIO=0): m0 and m1 both request → m0 served first, then m1. Repeating with both held → alternation m0, m1, m0, m1.
- Lock test: m1 asserts arvalid during m0's DATA phase → m1 is not granted until m0's rlast handshake, then granted with 1 IDLE cycle between.
- Backpressure: m1 (arlen=0, araddr=0x0f000000) deasserts rready for 3 cycles while s_rvalid is high → s_rready stays 0 and the beat is delivered once with no duplication.
- Length error: granted arlen=3 but the bus asserts rlast on beat 2 → o_len_err pulses one cycle at that beat and state returns to IDLE. Separately, 5 beats for arlen=3 → pulse on beat 4.
- Reset mid-DATA after beat 1 of 4 → next cycle o_busy=0, s_rready=0, o_grant=0. A new m1 request is granted normally.
